// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state encoding and default parameters for the I2C receive framer
package i2c_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } i2c_state_e;
  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h42;
  localparam int DEF_FILT_LEN = 3;
endpackage

// File: rtl/i2c_sig_filter.sv
// i2c_sig_filter: 2-flop synchronizer plus glitch filter; the output follows only after FILT_LEN equal samples
module i2c_sig_filter
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic filt_o
);
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [1:0]    sync_q;
  logic          filt_q, filt_d, differ, done;
  logic [CW-1:0] cnt_q, cnt_d;
  // count consecutive synchronized samples that disagree with the filtered level
  always_comb begin
    differ = sync_q[1] != filt_q;
    done   = differ && cnt_q == CW'(FILT_LEN - 1);
    cnt_d  = (differ && !done) ? cnt_q + 1'b1 : '0;
    filt_d = done ? sync_q[1] : filt_q;
  end
  // synchronizer and filter state; idle bus level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end
  assign filt_o = filt_q;
endmodule

// File: rtl/i2c_rx_framer.sv
// i2c_rx_framer: write-only I2C slave receiver with START/STOP detection, ACK generation and a one-byte buffer
module i2c_rx_framer
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter int         FILT_LEN   = DEF_FILT_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       start_det,
  output logic       stop_det,
  output logic       overflow,
  output logic       busy
);
  i2c_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d, byte_w;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       scl_f, sda_f, scl_p_q, sda_p_q;
  logic       ack_q, ack_d, skip_q, skip_d, sda_q, sda_d;
  logic       rx_valid_q, rx_valid_d, busy_q, busy_d;
  logic       start_q, stop_q, ovf_q, ovf_d;
  logic       scl_rise, scl_fall, scl_hold, start_ev, stop_ev, room;

  i2c_sig_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst_n(rst_n), .raw_i(scl_i), .filt_o(scl_f)
  );
  i2c_sig_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst_n(rst_n), .raw_i(sda_i), .filt_o(sda_f)
  );

  assign scl_rise = scl_f && !scl_p_q;
  assign scl_fall = !scl_f && scl_p_q;
  assign scl_hold = scl_f && scl_p_q;
  assign start_ev = scl_hold && sda_p_q && !sda_f;
  assign stop_ev  = scl_hold && !sda_p_q && sda_f;
  assign byte_w   = {shift_q[6:0], sda_f};
  assign room     = !rx_valid_q || rx_ready;

  // protocol FSM: bus conditions override everything, then bit collection and ACK slots
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    ack_d      = ack_q;
    skip_d     = skip_q;
    sda_d      = sda_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    busy_d     = busy_q;
    ovf_d      = 1'b0;
    if (stop_ev) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
      ack_d   = 1'b0;
      skip_d  = 1'b0;
    end else if (start_ev) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      sda_d     = 1'b1;
      busy_d    = 1'b1;
      ack_d     = 1'b0;
      skip_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (scl_rise) begin
            if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              shift_d   = byte_w;
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (state_q == ADDR) begin
                  state_d = (byte_w[7:1] == SLAVE_ADDR && !byte_w[0]) ? ADDR_ACK : IGNORE;
                end else if (room) begin
                  rx_data_d  = byte_w;
                  rx_valid_d = 1'b1;
                  state_d    = DATA_ACK;
                end else begin
                  ovf_d  = 1'b1;
                  skip_d = 1'b1;
                end
              end
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            ack_d = !ack_q;
            sda_d = ack_q;
            if (ack_q) begin
              state_d   = DATA;
              bit_cnt_d = 3'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // state registers; reset releases the bus and waits for a fresh START
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      ack_q      <= 1'b0;
      skip_q     <= 1'b0;
      sda_q      <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      ovf_q      <= 1'b0;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      ack_q      <= ack_d;
      skip_q     <= skip_d;
      sda_q      <= sda_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      start_q    <= start_ev;
      stop_q     <= stop_ev;
      ovf_q      <= ovf_d;
      scl_p_q    <= scl_f;
      sda_p_q    <= sda_f;
    end
  end

  assign sda_o     = sda_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_rx_framer.sv
// tb_i2c_rx_framer: bit-banged I2C master driving the framer, table-driven writes plus corner sequences
module tb_i2c_rx_framer;
  import i2c_pkg::*;
  localparam int Q = 250;
  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    logic       aack;
    logic       dack;
    logic       expb;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1, rx_ready = 1'b1;
  logic sda_o, rx_valid, start_det, stop_det, overflow, busy, bus_sda;
  logic [7:0] rx_data;
  logic [7:0] obs [256];
  logic [7:0] exp_q [$];
  int n_start = 0, n_stop = 0, n_ovf = 0, n_low = 0, obs_n = 0;
  int checks = 0, fails = 0, rd = 0;
  vec_t vecs [7];

  assign bus_sda = m_sda & sda_o;
  always #5 clk = ~clk;

  i2c_rx_framer dut (
    .clk(clk), .rst_n(rst_n), .scl_i(m_scl), .sda_i(bus_sda), .sda_o(sda_o),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .start_det(start_det), .stop_det(stop_det), .overflow(overflow), .busy(busy)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (start_det) n_start++;
      if (stop_det) n_stop++;
      if (overflow) n_ovf++;
      if (!sda_o) n_low++;
      if (rx_valid && rx_ready) begin
        obs[obs_n[7:0]] = rx_data;
        obs_n++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_c;
    m_sda = 1'b1; #Q; m_scl = 1'b1; #(2*Q); m_sda = 1'b0; #(2*Q); m_scl = 1'b0; #Q;
  endtask

  task automatic stop_c;
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #(2*Q);
  endtask

  task automatic wbit(input logic b);
    m_sda = b; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
  endtask

  task automatic rack(output logic a);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; a = bus_sda; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rack(a);
  endtask

  task automatic drain;
    while (exp_q.size() > 0) begin
      int t = 0;
      while (obs_n <= rd && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (obs_n <= rd) begin
        chk("sb_timeout", obs_n, rd + 1);
        void'(exp_q.pop_front());
      end else begin
        chk("sb_data", obs[rd[7:0]], exp_q.pop_front());
        rd++;
      end
    end
  endtask

  initial begin
    logic a;
    int s0, p0, l0, o0, c0;
    vecs[0] = '{7'h42, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{7'h43, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{7'h42, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{7'h42, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{7'h42, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{7'h21, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{7'h42, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1};
    #20;
    chk("rst_sda_o", sda_o, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {start_det, stop_det, overflow}, 3'b000);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int v = 0; v < 7; v++) begin
      s0 = n_start; p0 = n_stop; l0 = n_low;
      start_c;
      chk($sformatf("v%0d_start", v), n_start, s0 + 1);
      chk($sformatf("v%0d_busy", v), busy, 1);
      wbyte({vecs[v].addr, vecs[v].rw}, a);
      chk($sformatf("v%0d_addr_ack", v), a, !vecs[v].aack);
      if (vecs[v].rw) chk($sformatf("v%0d_ignore", v), 32'(dut.state_q), 32'(IGNORE));
      wbyte(vecs[v].data, a);
      chk($sformatf("v%0d_data_ack", v), a, !vecs[v].dack);
      if (vecs[v].expb) exp_q.push_back(vecs[v].data);
      stop_c;
      chk($sformatf("v%0d_stop", v), n_stop, p0 + 1);
      chk($sformatf("v%0d_idle", v), busy, 0);
      if (!vecs[v].aack) chk($sformatf("v%0d_sda_quiet", v), n_low, l0);
      drain;
    end
    rx_ready = 1'b0;
    o0 = n_ovf;
    start_c;
    wbyte({7'h42, 1'b0}, a);
    chk("ovf_addr_ack", a, 0);
    wbyte(8'h11, a);
    chk("ovf_first_ack", a, 0);
    wbyte(8'h22, a);
    chk("ovf_second_nack", a, 1);
    stop_c;
    chk("ovf_pulses", n_ovf, o0 + 1);
    chk("ovf_rx_data", rx_data, 8'h11);
    chk("ovf_rx_valid", rx_valid, 1);
    exp_q.push_back(8'h11);
    rx_ready = 1'b1;
    drain;
    repeat (5) @(negedge clk);
    chk("ovf_consumed", rx_valid, 0);
    c0 = n_start;
    @(negedge clk) m_sda = 1'b0;
    @(negedge clk) m_sda = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_no_start", n_start, c0);
    chk("glitch_not_busy", busy, 0);
    start_c;
    for (int i = 7; i >= 0; i--) wbit(i == 0 ? 1'b0 : (8'h84 >> i) & 1'b1);
    m_sda = 1'b1; #Q;
    chk("ack_reset_driving", sda_o, 0);
    rst_n = 1'b0;
    #1;
    chk("ack_reset_sda_o", sda_o, 1);
    chk("ack_reset_busy", busy, 0);
    #Q; rst_n = 1'b1; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
    o0 = obs_n;
    start_c;
    wbyte({7'h42, 1'b0}, a);
    chk("mid_addr_ack", a, 0);
    for (int i = 0; i < 4; i++) wbit(1'b1);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_sda_o", sda_o, 1);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_valid", rx_valid, 0);
    #Q; rst_n = 1'b1; #Q; m_scl = 1'b0; #Q;
    chk("mid_no_partial", obs_n, o0);
    start_c;
    wbyte({7'h42, 1'b0}, a);
    chk("post_addr_ack", a, 0);
    wbyte(8'h3C, a);
    chk("post_data_ack", a, 0);
    exp_q.push_back(8'h3C);
    stop_c;
    drain;
    chk("sb_extra", obs_n, rd);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
